req_ack_arbiter: RTL and testbench

- Shares one req/ack slave channel (single-cycle `slave_req` in, single-cycle `slave_ack` out) among N requesters.
- Requesters are served in round-robin order.
- Each slave transaction is issued on behalf of one latched owner, and the completion is returned to that owner only.
- A watchdog bounds how long the arbiter waits on a slave that may never complete.

---
 rtl/req_ack_arbiter_pkg.sv | 12 +
 rtl/req_ack_arbiter_rr_pick.sv | 30 +++
 rtl/req_ack_arbiter.sv | 89 ++++++++
 tb/tb_req_ack_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/req_ack_arbiter_pkg.sv
// Shared constants for the req/ack arbiter family: FSM state encoding and
// the default watchdog length.
package req_ack_arbiter_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] WAIT    = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/req_ack_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr,
// wrapping at N. No state, no latency.
module rr_pick
  import req_ack_arbiter_pkg::*;
#(
  parameter int N    = 4,
  parameter int IDXW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic            valid,
  output logic [IDXW-1:0] idx
);

  // Scan from the farthest offset down so the nearest match is written last.
  always_comb begin
    int j;
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/req_ack_arbiter.sv
// Round-robin sharing of one req/ack slave among N requesters, with a watchdog
// that abandons a transaction after TIMEOUT silent WAIT cycles.
module req_ack_arbiter
  import req_ack_arbiter_pkg::*;
#(
  parameter int N       = 4,
  parameter int IDXW    = 2,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    ack,
  output logic [N-1:0]    err,
  output logic [IDXW-1:0] owner,
  output logic            busy,
  output logic            slave_req,
  input  logic            slave_ack,
  output logic            stray_ack
);

  localparam logic [7:0]      TMAX = 8'(TIMEOUT - 1);
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);
  localparam logic [N-1:0]    ONE  = N'(1);

  logic [1:0]      state;
  logic [IDXW-1:0] ptr;
  logic [7:0]      timer;
  logic            pick_valid;
  logic [IDXW-1:0] pick_idx;

  rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      timer     <= '0;
      ack       <= '0;
      err       <= '0;
      slave_req <= 1'b0;
      busy      <= 1'b0;
      stray_ack <= 1'b0;
    end else begin
      slave_req <= 1'b0;
      ack       <= '0;
      err       <= '0;
      // A completion outside WAIT belongs to no one (e.g. arrives after a timeout).
      if (slave_ack && state != WAIT) stray_ack <= 1'b1;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner     <= pick_idx;
            slave_req <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (slave_ack) begin
            ack   <= ONE << owner;
            state <= RELEASE;
          end else if (timer == TMAX) begin
            err   <= ONE << owner;
            state <= RELEASE;
          end else if (timer != 8'hFF) begin
            timer <= timer + 8'd1;
          end
        end
        default: begin
          ptr   <= (owner == LAST) ? '0 : owner + 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_req_ack_arbiter.sv
// Randomized and directed bench for req_ack_arbiter, checked against a
// transaction-level round-robin model.
module tb_req_ack_arbiter;

  localparam int N       = 4;
  localparam int IDXW    = 2;
  localparam int TIMEOUT = 16;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    ack;
  logic [N-1:0]    err;
  logic [IDXW-1:0] owner;
  logic            busy;
  logic            slave_req;
  logic            slave_ack = 1'b0;
  logic            stray_ack;

  int n_chk  = 0;
  int n_pass = 0;
  int m_ptr  = 0;
  bit m_stray = 1'b0;

  always #5 clock = ~clock;

  req_ack_arbiter #(.N(N), .IDXW(IDXW), .TIMEOUT(TIMEOUT)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .ack       (ack),
    .err       (err),
    .owner     (owner),
    .busy      (busy),
    .slave_req (slave_req),
    .slave_ack (slave_ack),
    .stray_ack (stray_ack)
  );

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int rr_model(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  // One full transaction starting at a negedge in IDLE. d = WAIT cycle in
  // which the slave acks (d >= TIMEOUT means it never does). late = drive a
  // leftover slave_ack during this IDLE cycle.
  task automatic txn(input logic [N-1:0] add, input int d, input bit late);
    int w;
    int r;
    bit is_ack;
    req = req | add;
    w = rr_model(req, m_ptr);
    if (w < 0) begin
      chk("txn_has_req", 0, 1);
      return;
    end
    if (late) begin
      slave_ack = 1'b1;
      m_stray   = 1'b1;
    end
    @(negedge clock);
    slave_ack = 1'b0;
    chk("issue_slave_req", slave_req, 1);
    chk("issue_owner", owner, w);
    chk("issue_busy", busy, 1);
    chk("issue_no_resp", {ack, err}, 0);
    is_ack = (d < TIMEOUT);
    r = is_ack ? d : TIMEOUT - 1;
    for (int k = 0; k <= r; k++) begin
      @(negedge clock);
      slave_ack = (k == d);
      chk("wait_quiet", {ack, err, slave_req}, 0);
    end
    @(negedge clock);
    slave_ack = 1'b0;
    chk("rel_ack", ack, is_ack ? (1 << w) : 0);
    chk("rel_err", err, is_ack ? 0 : (1 << w));
    chk("rel_owner", owner, w);
    req[w] = 1'b0;
    m_ptr = (w + 1) % N;
    @(negedge clock);
    chk("idle_busy", busy, 0);
    chk("idle_no_pulse", {ack, err, slave_req}, 0);
    chk("stray", stray_ack, m_stray);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      chk("no_grant", {busy, slave_req, ack, err}, 0);
    end
  endtask

  initial begin
    logic [N-1:0] add;
    bit last_to;
    int d;

    repeat (2) @(negedge clock);
    chk("rst_outs", {ack, err, slave_req, busy, stray_ack}, 0);
    chk("rst_owner", owner, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Fairness: all four request, each drops after its completion.
    txn(4'b1111, 0, 1'b0);
    txn(4'b0000, 3, 1'b0);
    txn(4'b0000, 1, 1'b0);
    txn(4'b0000, 5, 1'b0);
    idle_cycles(2);

    // Single requester, ack two cycles after slave_req, then nothing.
    txn(4'b0100, 1, 1'b0);
    idle_cycles(3);

    // Wrap from ptr 3.
    txn(4'b0011, 2, 1'b0);
    txn(4'b0000, 0, 1'b0);

    // Timeout, then the late ack lands in IDLE.
    txn(4'b1000, TIMEOUT + 2, 1'b0);
    txn(4'b0001, 2, 1'b1);

    // Ack on the final WAIT cycle beats the watchdog.
    txn(4'b0100, TIMEOUT - 1, 1'b0);

    last_to = 1'b0;
    for (int t = 0; t < 40; t++) begin
      add = N'($urandom_range(0, 15));
      if ((req | add) == '0) add = N'(1) << $urandom_range(0, N - 1);
      d = $urandom_range(0, TIMEOUT + 2);
      txn(add, d, last_to && ($urandom_range(0, 1) == 1));
      last_to = (d >= TIMEOUT);
    end

    // Reset in the middle of WAIT.
    req = 4'b0010 | req;
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    req = '0;
    #1;
    chk("midrst_outs", {ack, err, slave_req, busy, stray_ack}, 0);
    chk("midrst_owner", owner, 0);
    m_ptr = 0;
    m_stray = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_idle", {busy, ack, err}, 0);
    txn(4'b0001, 3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
